test_sequencer: RTL and testbench

- Top-level controller for one speed-test run: latches test parameters on start, clears per-port statistics, gates the per-port frame generators for the requested number of milliseconds, then holds the receive checkers open for a drain window.
- Reports busy, the actual elapsed duration and a done pulse to the register/control interface.
- Sits between the config register block (test_config_t/port_config_t) and the per-port generator/checker datapaths.

---
 rtl/test_sequencer_if.sv | 45 ++++
 rtl/test_sequencer.sv | 135 +++++++++++++
 tb/tb_test_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/test_sequencer_if.sv
// test_sequencer_if: config/status bundle between the register block
// and the speed-test sequencer.
interface test_sequencer_if #(
  parameter int NUM_PORTS = 4
) ();
  logic [12:0]          cfg_duration;
  logic                 cfg_start;
  logic [NUM_PORTS-1:0] cfg_port_enable;
  logic                 stop_req;
  logic                 busy;
  logic [12:0]          actual_duration;
  logic                 stat_clear;
  logic [NUM_PORTS-1:0] gen_run;
  logic [NUM_PORTS-1:0] chk_run;
  logic                 ms_tick;
  logic                 done;

  modport master (
    output cfg_duration,
    output cfg_start,
    output cfg_port_enable,
    output stop_req,
    input  busy,
    input  actual_duration,
    input  stat_clear,
    input  gen_run,
    input  chk_run,
    input  ms_tick,
    input  done
  );

  modport slave (
    input  cfg_duration,
    input  cfg_start,
    input  cfg_port_enable,
    input  stop_req,
    output busy,
    output actual_duration,
    output stat_clear,
    output gen_run,
    output chk_run,
    output ms_tick,
    output done
  );
endinterface

// File: rtl/test_sequencer.sv
// test_sequencer: one speed-test run -- clear stats, generate for the
// requested ms, drain the checkers, then report elapsed time and done.
module test_sequencer #(
  parameter int NUM_PORTS     = 4,
  parameter int CYCLES_PER_MS = 125000,
  parameter int WAIT_MS       = 100
) (
  input logic             clk,
  input logic             rst_n,
  test_sequencer_if.slave bus
);

  localparam int PW = $clog2(CYCLES_PER_MS);
  localparam logic [PW-1:0] PRE_LAST = PW'(CYCLES_PER_MS - 1);
  localparam logic [12:0]   WAIT_LAST = 13'(WAIT_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        pre_q;
  logic [12:0]          ms_q;
  logic [12:0]          dur_q;
  logic [NUM_PORTS-1:0] en_q;
  logic                 busy_q;
  logic [12:0]          act_q;
  logic                 clr_q;
  logic [NUM_PORTS-1:0] gen_q;
  logic [NUM_PORTS-1:0] chk_q;
  logic                 tick_q;
  logic                 done_q;

  logic                 pre_wrap;
  logic [PW-1:0]        pre_d;
  logic [12:0]          ms_d;
  logic                 run_last;

  assign pre_wrap = (pre_q == PRE_LAST);
  assign pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
  assign ms_d     = ms_q + 13'd1;
  assign run_last = pre_wrap && (ms_d == dur_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      act_q   <= '0;
      clr_q   <= 1'b0;
      gen_q   <= '0;
      chk_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cfg_start) begin
            dur_q   <= bus.cfg_duration;
            en_q    <= bus.cfg_port_enable;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pre_q <= '0;
          ms_q  <= '0;
          chk_q <= en_q;
          if (dur_q == 13'd0) begin
            act_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            gen_q   <= en_q;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          pre_q <= pre_d;
          if (pre_wrap) begin
            tick_q <= 1'b1;
            ms_q   <= ms_d;
          end
          // Final tick outranks a coincident stop.
          if (run_last || bus.stop_req) begin
            act_q   <= run_last ? dur_q :
                       (pre_wrap ? ms_d : ms_q);
            gen_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          pre_q <= pre_d;
          if (pre_wrap) begin
            tick_q <= 1'b1;
            ms_q   <= ms_d;
            if (ms_d == WAIT_LAST) begin
              chk_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          pre_q   <= '0;
          ms_q    <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.actual_duration = act_q;
  assign bus.stat_clear      = clr_q;
  assign bus.gen_run         = gen_q;
  assign bus.chk_run         = chk_q;
  assign bus.ms_tick         = tick_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed and randomized runs against a
// run-level timing model of the sequencer.
module tb_test_sequencer;
  localparam int NP  = 4;
  localparam int CPM = 10;
  localparam int WMS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_sequencer_if #(.NUM_PORTS(NP)) bus ();

  test_sequencer #(
    .NUM_PORTS(NP),
    .CYCLES_PER_MS(CPM),
    .WAIT_MS(WMS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".gen"}, bus.gen_run, 0);
    check({tag, ".chk"}, bus.chk_run, 0);
    check({tag, ".done"}, bus.done, 0);
  endtask

  task automatic do_run(input logic [12:0] d,
                        input logic [NP-1:0] e,
                        input int stop_at,
                        input bit noise,
                        input bit do_rst);
    int run_len, exp_act, j_done;
    int clr_n, clr_pos, gen_n, gen_bad, chk_n, chk_bad;
    int tick_n, done_n, done_pos, busy_n, busy_after;
    bit seen_done;
    if (stop_at >= 0 && stop_at < int'(d) * CPM - 1) begin
      run_len = stop_at + 1;
      exp_act = run_len / CPM;
    end else begin
      run_len = int'(d) * CPM;
      exp_act = int'(d);
    end
    j_done = 1 + run_len + WMS * CPM;
    clr_n = 0; clr_pos = -1; gen_n = 0; gen_bad = 0;
    chk_n = 0; chk_bad = 0; tick_n = 0; done_n = 0;
    done_pos = -1; busy_n = 0; busy_after = -1;
    seen_done = 1'b0;

    @(negedge clk);
    bus.cfg_duration    = d;
    bus.cfg_port_enable = e;
    bus.cfg_start       = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    for (int j = 0; j < j_done + 10; j++) begin
      if (seen_done) begin
        busy_after = int'(bus.busy);
        break;
      end
      if (bus.stat_clear) begin
        clr_n++;
        if (clr_pos < 0) clr_pos = j;
      end
      if (bus.gen_run != '0) begin
        gen_n++;
        if (bus.gen_run != e) gen_bad++;
      end
      if (bus.chk_run != '0) begin
        chk_n++;
        if (bus.chk_run != e) chk_bad++;
      end
      if (bus.ms_tick) tick_n++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_pos < 0) done_pos = j;
        seen_done = 1'b1;
      end
      bus.stop_req = (j == stop_at + 1);
      if (noise) begin
        bus.cfg_start = (j == 4) || (j == run_len + 6);
        if (j == 3) begin
          bus.cfg_duration    = 13'($urandom);
          bus.cfg_port_enable = ~e;
        end
      end
      if (do_rst && j == 15) begin
        check("pre_rst.gen", bus.gen_run, e);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst.act", bus.actual_duration, 0);
        check("async_rst.clr", bus.stat_clear, 0);
        check("rst.no_done", done_n, 0);
        bus.stop_req  = 1'b0;
        bus.cfg_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bus.stop_req  = 1'b0;
    bus.cfg_start = 1'b0;
    check("done_seen", seen_done, 1);
    check("clr_n", clr_n, 1);
    check("clr_pos", clr_pos, 0);
    check("gen_cycles", gen_n, (e != '0) ? run_len : 0);
    check("gen_value", gen_bad, 0);
    check("chk_cycles", chk_n,
          (e != '0) ? run_len + WMS * CPM : 0);
    check("chk_value", chk_bad, 0);
    check("ticks", tick_n, exp_act + WMS);
    check("done_n", done_n, 1);
    check("done_pos", done_pos, j_done);
    check("busy_cycles", busy_n, j_done + 1);
    check("busy_after", busy_after, 0);
    check("act", bus.actual_duration, exp_act);
  endtask

  initial begin
    int k;
    logic [12:0] d;
    bus.cfg_duration    = '0;
    bus.cfg_start       = 1'b0;
    bus.cfg_port_enable = '0;
    bus.stop_req        = 1'b0;
    #12;
    check_idle("reset");
    check("reset.act", bus.actual_duration, 0);
    check("reset.tick", bus.ms_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // stop_req in IDLE must not start anything
    bus.stop_req = 1'b1;
    repeat (3) @(negedge clk);
    bus.stop_req = 1'b0;
    check_idle("idle_stop");

    do_run(13'd3, 4'b0101, -1, 1'b0, 1'b0);
    do_run(13'd5, 4'b1110, 23, 1'b0, 1'b0);
    do_run(13'd0, 4'b1111, -1, 1'b0, 1'b0);
    do_run(13'd4, 4'b1010, -1, 1'b1, 1'b0);
    do_run(13'd3, 4'b0110, -1, 1'b0, 1'b1);
    check("post_rst.act", bus.actual_duration, 0);
    do_run(13'd1, 4'b0011, -1, 1'b0, 1'b0);
    do_run(13'd2, 4'b1001, 19, 1'b0, 1'b0);
    do_run(13'd2, 4'b0000, -1, 1'b0, 1'b0);
    check("zero_en.act", bus.actual_duration, 2);

    for (int r = 0; r < 10; r++) begin
      d = 13'($urandom_range(0, 6));
      k = -1;
      if (d != 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, int'(d) * CPM - 2);
        if (k % CPM == CPM - 1) k = k - 1;
      end
      do_run(d, NP'($urandom), k,
             1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
